// File: rtl/exe_md_stage.sv
// exe_md_stage: EXE pipeline stage with an iterative MULT/DIV unit and architectural HI/LO.
// Build macro MD_EARLY_OUT_EN: trivial divides (divisor 0 or |dividend| < |divisor|) skip the iteration.
module exe_md_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned PAYLOAD_W  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid_in,
    output logic                 exe_allowin_out,
    input  logic                 mem_allowin_in,
    output logic                 exe_valid_out,
    input  logic                 exe_flush_in,
    input  logic [3:0]           id_mdop_in,
    input  logic [DATA_W-1:0]    id_src0_in,
    input  logic [DATA_W-1:0]    id_src1_in,
    input  logic [PAYLOAD_W-1:0] id_payload_in,
    output logic [PAYLOAD_W-1:0] exe_payload_out,
    output logic [DATA_W-1:0]    exe_mdres_out,
    output logic [DATA_W-1:0]    exe_hi_out,
    output logic [DATA_W-1:0]    exe_lo_out
);
    localparam int unsigned CNT_MAX = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t                 state_r, state_nx;
    logic [CNT_W-1:0]       cnt_r, cnt_nx;
    logic [DATA_W-1:0]      rem_r, rem_nx;
    logic [DATA_W-1:0]      quot_r, quot_nx;
    logic [DATA_W-1:0]      hi_res_r, hi_res_nx;
    logic [DATA_W-1:0]      lo_res_r, lo_res_nx;
    logic                   early_r, early_nx;

    logic                   valid_r;
    logic [3:0]             op_r;
    logic [DATA_W-1:0]      src0_r, src1_r;
    logic [PAYLOAD_W-1:0]   payload_r;
    logic [DATA_W-1:0]      hi_r, lo_r;

    logic                   is_mul, is_div, is_signed, ready, allowin, leave;
    logic                   q_neg, r_neg, div_early;
    logic [DATA_W-1:0]      a_mag, b_mag, early_q;
    logic [2*DATA_W-1:0]    ext_a, ext_b, prod;
    logic [DATA_W:0]        rem_sh, diff;
    logic [DATA_W-1:0]      step_rem, step_quot;

    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    // Decode and handshake
    assign is_mul    = (op_r == OP_MULT) || (op_r == OP_MULTU);
    assign is_div    = (op_r == OP_DIV)  || (op_r == OP_DIVU);
    assign is_signed = (op_r == OP_MULT) || (op_r == OP_DIV);
    assign ready     = !(is_mul || is_div) || (state_r == ST_DONE);
    assign allowin   = !valid_r || (ready && mem_allowin_in);
    assign leave     = valid_r && ready && mem_allowin_in && !exe_flush_in;

    assign exe_allowin_out = allowin;
    assign exe_valid_out   = valid_r && ready;
    assign exe_payload_out = payload_r;
    assign exe_hi_out      = hi_r;
    assign exe_lo_out      = lo_r;

    // Operand magnitudes and result signs; DIV works on magnitudes
    assign q_neg = is_signed && (src0_r[DATA_W-1] ^ src1_r[DATA_W-1]);
    assign r_neg = is_signed && src0_r[DATA_W-1];
    assign a_mag = neg_if(is_signed && src0_r[DATA_W-1], src0_r);
    assign b_mag = neg_if(is_signed && src1_r[DATA_W-1], src1_r);

    assign ext_a = {{DATA_W{is_signed & src0_r[DATA_W-1]}}, src0_r};
    assign ext_b = {{DATA_W{is_signed & src1_r[DATA_W-1]}}, src1_r};
    assign prod  = ext_a * ext_b;

    // One restoring-division step: shift in next dividend bit, trial subtract
    assign rem_sh    = {rem_r, quot_r[DATA_W-1]};
    assign diff      = rem_sh - {1'b0, b_mag};
    assign step_rem  = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    assign step_quot = {quot_r[DATA_W-2:0], ~diff[DATA_W]};

    assign early_q = (b_mag == '0) ? '1 : '0;
`ifdef MD_EARLY_OUT_EN
    assign div_early = (b_mag == '0) || (a_mag < b_mag);
`else
    assign div_early = 1'b0;
`endif

    // Next-state and datapath next values
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        rem_nx    = rem_r;
        quot_nx   = quot_r;
        hi_res_nx = hi_res_r;
        lo_res_nx = lo_res_r;
        early_nx  = early_r;
        if (exe_flush_in) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            early_nx = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_r && is_mul) begin
                        state_nx = ST_MUL;
                        cnt_nx   = '0;
                    end else if (valid_r && is_div) begin
                        state_nx = ST_DIV;
                        cnt_nx   = '0;
                        rem_nx   = '0;
                        quot_nx  = a_mag;
                        early_nx = div_early;
                        // Trivial divide: result known now, DIV state is then a single pass-through cycle
                        if (div_early) begin
                            hi_res_nx = neg_if(r_neg, a_mag);
                            lo_res_nx = neg_if(q_neg, early_q);
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_r == CNT_W'(MUL_CYCLES - 1)) begin
                        state_nx               = ST_DONE;
                        {hi_res_nx, lo_res_nx} = prod;
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (early_r) begin
                        state_nx = ST_DONE;
                        early_nx = 1'b0;
                    end else begin
                        rem_nx  = step_rem;
                        quot_nx = step_quot;
                        if (cnt_r == CNT_W'(DATA_W - 1)) begin
                            state_nx  = ST_DONE;
                            hi_res_nx = neg_if(r_neg, step_rem);
                            lo_res_nx = neg_if(q_neg, step_quot);
                        end else begin
                            cnt_nx = cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (mem_allowin_in) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // FSM and MUL/DIV datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            rem_r    <= '0;
            quot_r   <= '0;
            hi_res_r <= '0;
            lo_res_r <= '0;
            early_r  <= 1'b0;
        end else begin
            state_r  <= state_nx;
            cnt_r    <= cnt_nx;
            rem_r    <= rem_nx;
            quot_r   <= quot_nx;
            hi_res_r <= hi_res_nx;
            lo_res_r <= lo_res_nx;
            early_r  <= early_nx;
        end
    end

    // Pipeline registers; flush wins over a same-cycle load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            op_r      <= '0;
            src0_r    <= '0;
            src1_r    <= '0;
            payload_r <= '0;
        end else if (exe_flush_in) begin
            valid_r <= 1'b0;
        end else if (allowin) begin
            valid_r <= id_valid_in;
            if (id_valid_in) begin
                op_r      <= id_mdop_in;
                src0_r    <= id_src0_in;
                src1_r    <= id_src1_in;
                payload_r <= id_payload_in;
            end
        end
    end

    // Architectural HI/LO change only when the owning instruction leaves EXE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (leave) begin
            case (op_r)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    hi_r <= hi_res_r;
                    lo_r <= lo_res_r;
                end
                OP_MTHI: hi_r <= src0_r;
                OP_MTLO: lo_r <= src0_r;
                default: ;
            endcase
        end
    end

    always_comb begin
        exe_mdres_out = '0;
        if (op_r == OP_MFHI)      exe_mdres_out = hi_r;
        else if (op_r == OP_MFLO) exe_mdres_out = lo_r;
    end
endmodule

// File: tb/tb_exe_md_stage.sv
// tb_exe_md_stage: scoreboard bench for exe_md_stage (default parameters).
// Honours MD_EARLY_OUT_EN for the expected divide-by-zero latency.
module tb_exe_md_stage;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned MC = 2;
`ifdef MD_EARLY_OUT_EN
    localparam int DIV0_LAT = 2;
`else
    localparam int DIV0_LAT = DW + 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid_in;
    logic          exe_allowin_out;
    logic          mem_allowin_in;
    logic          exe_valid_out;
    logic          exe_flush_in;
    logic [3:0]    id_mdop_in;
    logic [DW-1:0] id_src0_in, id_src1_in;
    logic [PW-1:0] id_payload_in;
    logic [PW-1:0] exe_payload_out;
    logic [DW-1:0] exe_mdres_out, exe_hi_out, exe_lo_out;

    always #5 clk = ~clk;

    exe_md_stage #(.DATA_W(DW), .MUL_CYCLES(MC), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_in(id_valid_in), .exe_allowin_out(exe_allowin_out),
        .mem_allowin_in(mem_allowin_in), .exe_valid_out(exe_valid_out),
        .exe_flush_in(exe_flush_in), .id_mdop_in(id_mdop_in),
        .id_src0_in(id_src0_in), .id_src1_in(id_src1_in),
        .id_payload_in(id_payload_in), .exe_payload_out(exe_payload_out),
        .exe_mdres_out(exe_mdres_out), .exe_hi_out(exe_hi_out), .exe_lo_out(exe_lo_out)
    );

    typedef struct {
        logic [PW-1:0] pl;
        logic [DW-1:0] mdres;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] mdl_hi = '0, mdl_lo = '0;
    int            pl_n = 0;
    bit            pend = 1'b0;
    logic [DW-1:0] pend_hi, pend_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of HI/LO and MF results in program order
    task automatic model_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            output logic [DW-1:0] mdres);
        logic [63:0] p;
        int          sa, sb;
        mdres = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd1: begin p = 64'(longint'(sa) * longint'(sb)); mdl_hi = p[63:32]; mdl_lo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; mdl_hi = p[63:32]; mdl_lo = p[31:0]; end
            4'd3: begin
                if (b == 0) begin
                    mdl_lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                    mdl_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mdl_lo = a;
                    mdl_hi = '0;
                end else begin
                    mdl_lo = 32'(sa / sb);
                    mdl_hi = 32'(sa % sb);
                end
            end
            4'd4: begin
                if (b == 0) begin
                    mdl_lo = 32'hFFFF_FFFF;
                    mdl_hi = a;
                end else begin
                    mdl_lo = a / b;
                    mdl_hi = a % b;
                end
            end
            4'd5: mdl_hi = a;
            4'd6: mdl_lo = a;
            4'd7: mdres = mdl_hi;
            4'd8: mdres = mdl_lo;
            default: ;
        endcase
    endtask

    // Present an instruction until EXE accepts it; optionally record its expected outcome
    task automatic issue_start(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input bit push);
        bit   acc;
        exp_t e;
        pl_n++;
        id_mdop_in    = op;
        id_src0_in    = a;
        id_src1_in    = b;
        id_payload_in = 64'(pl_n) * 64'h0001_0003_0005_0007;
        id_valid_in   = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (exe_allowin_out) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        id_valid_in = 1'b0;
        check("accept", 64'(acc), 64'd1);
        if (acc && push) begin
            e.pl = id_payload_in;
            model_op(op, a, b, e.mdres);
            e.hi = mdl_hi;
            e.lo = mdl_lo;
            sb.push_back(e);
        end
    endtask

    // Wait for exe_valid_out; measures posedges since entry
    task automatic wait_done(input int exp_lat, input bit chk_busy);
        int lat;
        bit busy, done;
        lat = 0; busy = 1'b0; done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exe_valid_out) begin
                done = 1'b1;
                break;
            end
            if (exe_allowin_out) busy = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check("done", 64'(done), 64'd1);
        if (exp_lat >= 0) check("latency", 64'(lat), 64'(exp_lat));
        if (chk_busy) check("allowin_busy", 64'(busy), 64'd0);
    endtask

    task automatic run(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int exp_lat, input bit chk_busy);
        issue_start(op, a, b, 1'b1);
        wait_done(exp_lat, chk_busy);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on every leave, check HI/LO one cycle later after commit
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            check("hi", 64'(exe_hi_out), 64'(pend_hi));
            check("lo", 64'(exe_lo_out), 64'(pend_lo));
            pend = 1'b0;
        end
        if (rst_n && exe_valid_out && mem_allowin_in && !exe_flush_in) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("payload", exe_payload_out, e.pl);
                check("mdres", 64'(exe_mdres_out), 64'(e.mdres));
                pend    = 1'b1;
                pend_hi = e.hi;
                pend_lo = e.lo;
            end
        end
    end

    initial begin
        logic [DW-1:0] old_hi, old_lo;
        int            seen;
        logic [3:0]    rop;
        logic [DW-1:0] ra, rb;

        rst_n = 1'b0; id_valid_in = 1'b0; mem_allowin_in = 1'b1; exe_flush_in = 1'b0;
        id_mdop_in = '0; id_src0_in = '0; id_src1_in = '0; id_payload_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_allowin", 64'(exe_allowin_out), 64'd1);
        check("rst_valid", 64'(exe_valid_out), 64'd0);
        check("rst_mdres", 64'(exe_mdres_out), 64'd0);
        check("rst_hi", 64'(exe_hi_out), 64'd0);
        check("rst_lo", 64'(exe_lo_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(4'd1, 32'hFFFF_FFFD, 32'd5, MC + 1, 1'b1);
        run(4'd4, 32'd100, 32'd7, DW + 1, 1'b1);
        run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DW + 1, 1'b1);
        run(4'd3, 32'hFFFF_FFF9, 32'd2, DW + 1, 1'b1);
        run(4'd3, 32'd7, 32'hFFFF_FFFE, DW + 1, 1'b1);
        run(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC + 1, 1'b1);
        run(4'd8, 32'd0, 32'd0, 0, 1'b0);
        run(4'd0, 32'h1234, 32'h5678, 0, 1'b0);
        run(4'd4, 32'd9, 32'd0, DIV0_LAT, 1'b1);

        // MULTU held in DONE by MEM back-pressure
        old_hi = mdl_hi;
        old_lo = mdl_lo;
        mem_allowin_in = 1'b0;
        issue_start(4'd2, 32'd2, 32'd3, 1'b1);
        wait_done(MC + 1, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_valid", 64'(exe_valid_out), 64'd1);
            check("bp_hi", 64'(exe_hi_out), 64'(old_hi));
            check("bp_lo", 64'(exe_lo_out), 64'(old_lo));
        end
        @(posedge clk);
        #1;
        mem_allowin_in = 1'b1;
        @(posedge clk);
        #1;

        // Flush a DIV mid-iteration while ID offers an MTLO in the same cycle
        old_hi = mdl_hi;
        old_lo = mdl_lo;
        issue_start(4'd3, 32'd1000, 32'd3, 1'b0);
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        exe_flush_in  = 1'b1;
        id_valid_in   = 1'b1;
        id_mdop_in    = 4'd6;
        id_src0_in    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        exe_flush_in = 1'b0;
        id_valid_in  = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(exe_valid_out), 64'd0);
        check("flush_allowin", 64'(exe_allowin_out), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (exe_valid_out) seen++;
        end
        check("flush_quiet", 64'(seen), 64'd0);
        check("flush_hi", 64'(exe_hi_out), 64'(old_hi));
        check("flush_lo", 64'(exe_lo_out), 64'(old_lo));
        @(posedge clk);
        #1;

        run(4'd5, 32'hA5A5_A5A5, 32'd0, 0, 1'b0);
        run(4'd7, 32'd0, 32'd0, 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            rop = 4'($urandom_range(0, 10));
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
            run(rop, ra, rb, -1, 1'b0);
        end

        // Reset in the middle of a multiply
        run(4'd5, 32'h0000_1234, 32'd0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        issue_start(4'd2, 32'd7, 32'd7, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk);
        check("mrst_hi", 64'(exe_hi_out), 64'd0);
        check("mrst_lo", 64'(exe_lo_out), 64'd0);
        check("mrst_valid", 64'(exe_valid_out), 64'd0);
        check("mrst_allowin", 64'(exe_allowin_out), 64'd1);

        repeat (3) @(posedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
